cabac_ctx_init: RTL and testbench
=================================

// Module: cabac_ctx_init
// PURPOSE
//  Slice-start context initialiser for the CABAC engine. On start_i it walks context
//  indices 0..CTX_NUM-1 and reads each 8-bit initValue from an external synchronous
//  init table. It derives the HEVC initial 7-bit state from the slice QP and writes
//  that state into the 2-port 7x64 context state memory through its write port
//  (w_en / w_addr / w_data). Sits directly upstream of the context state memory.
// PARAMETERS
//  CTX_NUM     64  number of contexts initialised per start, 1..2**ADDR_WIDTH
//  ADDR_WIDTH  6   context address width
//  QP_WIDTH    6   slice QP width, unsigned
// PORTS
//  clk           in   1           clock
//  rst           in   1           asynchronous reset, active-high
//  start_i       in   1           one-cycle pulse: begin initialisation
//  slice_qp_i    in   QP_WIDTH    slice QP, sampled on the accepted start_i
//  table_addr_o  out  ADDR_WIDTH  init table read address
//  table_en_o    out  1           init table read enable, active-high
//  table_data_i  in   8           initValue, valid the cycle after table_en_o
//  w_en_o        out  1           context memory write enable, active-high
//  w_addr_o      out  ADDR_WIDTH  context memory write address
//  w_data_o      out  7           {pStateIdx[5:0], valMps}
//  busy_o        out  1           initialisation in progress
//  done_o        out  1           one-cycle pulse after the last write
// BEHAVIOUR
//  - Reset (async, any time): FSM=IDLE. All outputs, rd counter and qp register = 0.
//    Reset mid-run aborts with no further writes, so the memory is partially initialised.
//  - FSM: IDLE -start_i-> RUN -last read issued-> DRAIN -last write-> DONE -> IDLE.
//  - start_i is accepted only in IDLE. Edge E0 latches qp_r = min(slice_qp_i, 51),
//    sets busy_o=1, table_en_o=1 and table_addr_o=0. start_i in RUN/DRAIN/DONE is ignored.
//  - RUN: table_addr_o increments by 1 each cycle up to CTX_NUM-1. The next edge
//    drops table_en_o and enters DRAIN. There are no gaps and no back-pressure.
//  - Datapath (1 register stage): the table_data_i returned for address k is computed
//    combinationally and registered. The result is w_en_o=1, w_addr_o=k, one cycle later.
//    The first write is visible after E2. Write k is visible after E(k+2).
//  - The write address is a delayed copy of table_addr_o, not a separate counter.
//  - Arithmetic, with m=table_data_i[7:4] and n=table_data_i[3:0]:
//    slope  = 5*m - 45         signed, range -45..30
//    offset = (n<<3) - 16      signed, range -16..104
//    prod   = slope*qp_r       signed 13b, range -2295..1530
//    pre    = clip(1,126, (prod>>>4) + offset)   (>>> is arithmetic, floor)
//    valMps = (pre > 63). pStateIdx = valMps ? pre-64 : 63-pre.
//  - DRAIN: w_en_o=1 for the final write, addr CTX_NUM-1, visible after E(CTX_NUM+1).
//    The next edge enters DONE: w_en_o=0, done_o=1 for one cycle, busy_o still 1.
//    The edge after that enters IDLE: done_o=0, busy_o=0.
//  - Total: start accepted at E0 -> done_o high after E(CTX_NUM+2), i.e. E66 for 64 contexts.
//  - w_addr_o/w_data_o hold their last value when w_en_o=0. The memory ignores them.
//  - CTX_NUM=1: table_en_o is high for exactly one cycle and the FSM goes straight
//    to DRAIN.
//  - Downstream readers must not read the context memory while busy_o=1.
//    This block does not arbitrate.
// TESTING
//  T1 table[k]=154 (0x9A) for all k, qp=26 -> 64 writes, addr 0..63 consecutive,
//     w_data=7'h01, done_o after E66.
//  T2 table=0x8B, qp=26 -> pre=63 -> w_data=7'h00 (boundary valMps=0, pState=0).
//  T3 table=0x00, qp=51 -> pre clipped to 1 -> w_data=7'h7C.
//     table=0xFF, qp=51 -> pre clipped to 126 -> w_data=7'h7D.
//  T4 slice_qp_i=63 with table=0xFF -> same as qp=51 (7'h7D), confirming QP clip.
//     qp=0 with table=0x9A -> 7'h01.
//  T5 start_i re-pulsed at E10 and E40 while busy -> ignored.
//     Exactly 64 writes and one done_o; qp_r unchanged.
//  T6 rst asserted at E20 mid-run -> all outputs 0 immediately.
//     After release, a fresh start_i yields a full clean 64-write sequence.
//  T7 compare every w_data_o against a reference model for random table/qp,
//     for CTX_NUM=64 and CTX_NUM=1.

Source files
------------

// File: rtl/cabac_ctx_init.sv
// Slice-start CABAC context initialiser: streams initValues from a synchronous table,
// maps each to a 7-bit {pStateIdx, valMps} using the slice QP, and writes context memory.
`timescale 1ns/1ps
module cabac_ctx_init #(
  parameter int unsigned CTX_NUM    = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned QP_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [QP_WIDTH-1:0]   slice_qp_i,
  output logic [ADDR_WIDTH-1:0] table_addr_o,
  output logic                  table_en_o,
  input  logic [7:0]            table_data_i,
  output logic                  w_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [6:0]            w_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(CTX_NUM - 1);
  localparam logic [QP_WIDTH-1:0]   QpMax    = QP_WIDTH'(51);

  state_e                state_q, state_d;
  logic [QP_WIDTH-1:0]   qp_q, qp_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  en_d;
  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic [3:0]         m, n;
  logic signed [7:0]  slope, offset;
  logic signed [12:0] prod, sum;
  logic [6:0]         pre;
  logic               val_mps;
  logic [5:0]         p_state;

  always_comb begin
    state_d = state_q;
    qp_d    = qp_q;
    addr_d  = table_addr_o;
    en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          qp_d    = (slice_qp_i > QpMax) ? QpMax : slice_qp_i;
          addr_d  = '0;
          en_d    = 1'b1;
        end
      end
      StRun: begin
        if (table_addr_o == LastAddr) begin
          state_d = StDrain;
        end else begin
          addr_d = table_addr_o + ADDR_WIDTH'(1);
          en_d   = 1'b1;
        end
      end
      // Leave once the last table read has been turned into a write.
      StDrain: if (!rd_vld_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m       = table_data_i[7:4];
    n       = table_data_i[3:0];
    slope   = $signed({4'b0000, m}) * 8'sd5 - 8'sd45;
    offset  = $signed({1'b0, n, 3'b000}) - 8'sd16;
    prod    = $signed({{5{slope[7]}}, slope}) * $signed({{(13 - QP_WIDTH){1'b0}}, qp_q});
    sum     = (prod >>> 4) + $signed({{5{offset[7]}}, offset});
    if (sum < 13'sd1) begin
      pre = 7'd1;
    end else if (sum > 13'sd126) begin
      pre = 7'd126;
    end else begin
      pre = sum[6:0];
    end
    val_mps = pre[6];
    p_state = val_mps ? pre[5:0] : 6'd63 - pre[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      qp_q         <= '0;
      table_addr_o <= '0;
      table_en_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      qp_q         <= qp_d;
      table_addr_o <= addr_d;
      table_en_o   <= en_d;
      busy_o       <= (state_d != StIdle);
      done_o       <= (state_d == StDone);
    end
  end

  // Table data arrives one cycle after the read, so the address is delayed to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      w_en_o    <= 1'b0;
      w_addr_o  <= '0;
      w_data_o  <= '0;
    end else begin
      rd_vld_q  <= table_en_o;
      rd_addr_q <= table_addr_o;
      w_en_o    <= rd_vld_q;
      if (rd_vld_q) begin
        w_addr_o <= rd_addr_q;
        w_data_o <= {p_state, val_mps};
      end
    end
  end

endmodule

// File: tb/tb_cabac_ctx_init.sv
// Directed bench for cabac_ctx_init: 64-context instance plus a single-context instance.
`timescale 1ns/1ps
module tb_cabac_ctx_init;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [5:0] slice_qp, slice_qp1;
  logic [5:0] table_addr, table_addr1, w_addr, w_addr1;
  logic       table_en, table_en1, w_en, w_en1, busy, busy1, done, done1;
  logic [7:0] table_data, table_data1;
  logic [6:0] w_data, w_data1;

  logic [7:0] tbl [64];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cabac_ctx_init #(.CTX_NUM(64), .ADDR_WIDTH(6), .QP_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .slice_qp_i(slice_qp),
    .table_addr_o(table_addr), .table_en_o(table_en), .table_data_i(table_data),
    .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data), .busy_o(busy), .done_o(done)
  );

  cabac_ctx_init #(.CTX_NUM(1), .ADDR_WIDTH(6), .QP_WIDTH(6)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .slice_qp_i(slice_qp1),
    .table_addr_o(table_addr1), .table_en_o(table_en1), .table_data_i(table_data1),
    .w_en_o(w_en1), .w_addr_o(w_addr1), .w_data_o(w_data1), .busy_o(busy1), .done_o(done1)
  );

  // Synchronous init table shared by both instances.
  always @(posedge clk) begin
    if (table_en)  table_data  <= tbl[table_addr];
    if (table_en1) table_data1 <= tbl[table_addr1];
  end

  int         cyc = 0, wr_cnt = 0, done_cnt = 0;
  int         wr1_cnt = 0, done1_cnt = 0, ten1_cnt = 0;
  logic [5:0] log_addr [4096];
  logic [6:0] log_data [4096];
  int         log_cyc  [4096];
  logic [5:0] last1_addr = '0;
  logic [6:0] last1_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (w_en) begin
      log_addr[wr_cnt[11:0]] <= w_addr;
      log_data[wr_cnt[11:0]] <= w_data;
      log_cyc[wr_cnt[11:0]]  <= cyc + 1;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (w_en1) begin
      last1_addr <= w_addr1;
      last1_data <= w_data1;
      wr1_cnt    <= wr1_cnt + 1;
    end
    if (done1)     done1_cnt <= done1_cnt + 1;
    if (table_en1) ten1_cnt  <= ten1_cnt + 1;
  end

  function automatic logic [6:0] ref_state(input logic [7:0] v, input int qp);
    int q, slope, off, prod, pre;
    q     = (qp > 51) ? 51 : qp;
    slope = 5 * int'(v[7:4]) - 45;
    off   = int'(v[3:0]) * 8 - 16;
    prod  = slope * q;
    pre   = (prod >>> 4) + off;
    if (pre < 1)   pre = 1;
    if (pre > 126) pre = 126;
    if (pre > 63) return {6'(pre - 64), 1'b1};
    return {6'(63 - pre), 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) tbl[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) tbl[i] = 8'($urandom_range(0, 255));
  endtask

  // Full 64-context run; checks handshake timing, address order and data vs. model.
  task automatic run64(input int qp, input bit inject, input string tag, output int base);
    int base_d, e0, k, errs, idx;
    @(negedge clk);
    start    = 1'b1;
    slice_qp = 6'(qp);
    base     = wr_cnt;
    base_d   = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    e0    = cyc;
    check({tag, " start"}, {busy, table_en, 2'b00, table_addr}, {1'b1, 1'b1, 8'h00});
    k = 0;
    while (k < 200 && !done) begin
      @(posedge clk); #1;
      k++;
      if (inject && (k == 10 || k == 40)) begin
        start    = 1'b1;
        slice_qp = 6'd0;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, " done latency"}, k, 66);
    check({tag, " busy at done"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, " idle after done"}, {done, busy}, 2'b00);
    check({tag, " write count"}, wr_cnt - base, 64);
    check({tag, " done count"}, done_cnt - base_d, 1);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      idx = base + i;
      if (log_addr[idx[11:0]] !== 6'(i) || log_cyc[idx[11:0]] != e0 + 3 + i ||
          log_data[idx[11:0]] !== ref_state(tbl[i], qp)) errs++;
    end
    check({tag, " model errors"}, errs, 0);
  endtask

  task automatic check_all(input int base, input logic [6:0] exp, input string tag);
    int errs, idx;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      idx = base + i;
      if (log_data[idx[11:0]] !== exp) errs++;
    end
    check({tag, " first data"}, log_data[base[11:0]], exp);
    check({tag, " all data"}, errs, 0);
  endtask

  task automatic run1(input int qp, input string tag);
    int bw, bt, bd, k;
    @(negedge clk);
    start1    = 1'b1;
    slice_qp1 = 6'(qp);
    bw = wr1_cnt;
    bt = ten1_cnt;
    bd = done1_cnt;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    while (k < 20 && !done1) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " done latency"}, k, 3);
    @(posedge clk); #1;
    check({tag, " idle"}, {done1, busy1}, 2'b00);
    check({tag, " table_en cycles"}, ten1_cnt - bt, 1);
    check({tag, " write count"}, wr1_cnt - bw, 1);
    check({tag, " done count"}, done1_cnt - bd, 1);
    check({tag, " addr"}, last1_addr, 6'd0);
    check({tag, " data"}, last1_data, ref_state(tbl[0], qp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int b, bw;
    rst = 1'b0; start = 1'b0; start1 = 1'b0; slice_qp = '0; slice_qp1 = '0;
    fill(8'h00);
    #2 rst = 1'b1;
    #1;
    check("reset outputs", {table_en, table_addr, w_en, w_addr, w_data, busy, done}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    fill(8'h9A); run64(26, 1'b0, "T1", b); check_all(b, 7'h01, "T1");
    fill(8'h8B); run64(26, 1'b0, "T2", b); check_all(b, 7'h00, "T2");
    fill(8'h00); run64(51, 1'b0, "T3 lo", b); check_all(b, 7'h7C, "T3 lo");
    fill(8'hFF); run64(51, 1'b0, "T3 hi", b); check_all(b, 7'h7D, "T3 hi");
    fill(8'hFF); run64(63, 1'b0, "T4 qp63", b); check_all(b, 7'h7D, "T4 qp63");
    fill(8'h9A); run64(0, 1'b0, "T4 qp0", b); check_all(b, 7'h01, "T4 qp0");
    fill(8'hFF); run64(51, 1'b1, "T5", b); check_all(b, 7'h7D, "T5");

    // Abort mid-run with asynchronous reset.
    fill_rand();
    @(negedge clk);
    start = 1'b1; slice_qp = 6'd26;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("T6 async reset", {table_en, table_addr, w_en, w_addr, w_data, busy, done}, '0);
    bw = wr_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("T6 no writes after abort", wr_cnt - bw, 0);
    run64(26, 1'b0, "T6 fresh", b);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run64(int'($urandom_range(0, 63)), 1'b0, "T7 rand64", b);
    end
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run1(int'($urandom_range(0, 63)), "T7 ctx1");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
